// File: rtl/sequential_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Valid/ready request and result handshakes around an IDLE/RUN/DONE FSM.
module sequential_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_out;
  logic             c_msb;
  logic             last;

  // Slice adder for the current chunk; carry into the MSB recovered by XOR.
  always_comb begin
    a_ch  = a_q[idx_q*CHUNK +: CHUNK];
    b_ch  = b_q[idx_q*CHUNK +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch}
                  + {1'b0, b_ch}
                  + {{CHUNK{1'b0}}, cy_q};
    c_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    last  = (idx_q == IW'(N - 1));
  end

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (valid_i) begin
          a_d     = add1_i;
          b_d     = sub_i ? ~add2_i : add2_i;
          cy_d    = carry_i ^ sub_i;
          idx_d   = '0;
          rdy_d   = 1'b0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_ch;
        cy_d  = c_out;
        idx_d = idx_q + IW'(1);
        if (last) begin
          co_d    = c_out;
          ov_d    = c_msb ^ c_out;
          idx_d   = '0;
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (ready_i) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign ready_o    = rdy_q;
  assign valid_o    = vld_q;
  assign sum_o      = sum_q;
  assign carry_o    = co_q;
  assign overflow_o = ov_q;

endmodule

// File: tb/tb_sequential_chunk_adder.sv
// Bench for sequential_chunk_adder: CHUNK=8, 32 and 1 instances share stimulus.
// Results checked against a signed/unsigned integer arithmetic model.
module tb_sequential_chunk_adder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] add1_i;
  logic [31:0] add2_i;
  logic        sub_i;
  logic        carry_i;

  logic [31:0] sum_w [3];
  logic        co_w  [3];
  logic        ov_w  [3];
  logic        vo_w  [3];
  logic        rdy_w [3];

  logic [31:0] sum_g [3];
  logic        co_g  [3];
  logic        ov_g  [3];
  int          lat_g [3];
  int          exp_lat [3] = '{4, 1, 32};

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  sequential_chunk_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(valid_i), .ready_o(rdy_w[0]),
    .add1_i(add1_i), .add2_i(add2_i),
    .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(vo_w[0]), .ready_i(ready_i),
    .sum_o(sum_w[0]), .carry_o(co_w[0]),
    .overflow_o(ov_w[0])
  );

  sequential_chunk_adder #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(valid_i), .ready_o(rdy_w[1]),
    .add1_i(add1_i), .add2_i(add2_i),
    .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(vo_w[1]), .ready_i(ready_i),
    .sum_o(sum_w[1]), .carry_o(co_w[1]),
    .overflow_o(ov_w[1])
  );

  sequential_chunk_adder #(.WIDTH(32), .CHUNK(1)) u2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(valid_i), .ready_o(rdy_w[2]),
    .add1_i(add1_i), .add2_i(add2_i),
    .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(vo_w[2]), .ready_i(ready_i),
    .sum_o(sum_w[2]), .carry_o(co_w[2]),
    .overflow_o(ov_w[2])
  );

  // Reference: exact integer arithmetic, then wrap / range test.
  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    input  logic        c,
    output logic [31:0] sum,
    output logic        co,
    output logic        ov
  );
    longint sa, sb, ua, ub, cc, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    cc = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      r  = sa + sb + cc;
      co = (ua + ub + cc) > 64'sd4294967295;
    end else begin
      r  = sa - sb - cc;
      co = ua >= (ub + cc);
    end
    ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    sum = r[31:0];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request to all instances and collect each first result.
  task automatic txn(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic        c
  );
    int  n;
    bit  done [3];
    ready_i = 1'b1;
    n = 0;
    while (!(rdy_w[0] && rdy_w[1] && rdy_w[2]) && n < 100) begin
      step();
      n++;
    end
    add1_i  = a;
    add2_i  = b;
    sub_i   = s;
    carry_i = c;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    add1_i  = $urandom;
    add2_i  = $urandom;
    sub_i   = 1'($urandom);
    carry_i = 1'($urandom);
    for (int j = 0; j < 3; j++) begin
      done[j]  = 1'b0;
      lat_g[j] = -1;
    end
    for (int l = 1; l <= 40; l++) begin
      if (done[0] && done[1] && done[2]) break;
      step();
      for (int j = 0; j < 3; j++) begin
        if (!done[j] && vo_w[j] === 1'b1) begin
          sum_g[j] = sum_w[j];
          co_g[j]  = co_w[j];
          ov_g[j]  = ov_w[j];
          lat_g[j] = l;
          done[j]  = 1'b1;
        end
      end
    end
    checks++;
    if (!(done[0] && done[1] && done[2])) begin
      failures++;
      $display("FAIL txn_timeout done=%0d%0d%0d required=111",
               done[0], done[1], done[2]);
    end
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    add1_i  = '0;
    add2_i  = '0;
    sub_i   = 1'b0;
    carry_i = 1'b0;
    #2;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rdy_w[j] !== 1'b1 || vo_w[j] !== 1'b0 ||
          sum_w[j] !== 32'h0 || co_w[j] !== 1'b0 ||
          ov_w[j] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst=%0d rdy=%b vo=%b sum=%h co=%b ov=%b required 1 0 0 0 0",
                 j, rdy_w[j], vo_w[j], sum_w[j], co_w[j], ov_w[j]);
      end
    end
    rst_ni = 1'b1;
    txn(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (sum_g[j] !== 32'h8 || lat_g[j] != exp_lat[j]) begin
        failures++;
        $display("FAIL first_accept inst=%0d sum=%h lat=%0d required 8 lat=%0d",
                 j, sum_g[j], lat_g[j], exp_lat[j]);
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic test_directed();
    vec_t v [6];
    v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1};
    v[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1, 1};
    v[2] = '{32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0};
    v[3] = '{32'd13, 32'hFFFF_FFF9, 1, 0, 32'd20, 0, 0};
    v[4] = '{32'd20, 32'd7, 1, 0, 32'd13, 1, 0};
    v[5] = '{32'd20, 32'd7, 1, 1, 32'd12, 1, 0};
    for (int i = 0; i < 6; i++) begin
      txn(v[i].a, v[i].b, v[i].s, v[i].c);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (sum_g[j] !== v[i].sum || co_g[j] !== v[i].co ||
            ov_g[j] !== v[i].ov || lat_g[j] != exp_lat[j]) begin
          failures++;
          $display("FAIL directed_%0d inst=%0d got sum=%h co=%b ov=%b lat=%0d required sum=%h co=%b ov=%b lat=%0d",
                   i, j, sum_g[j], co_g[j], ov_g[j], lat_g[j],
                   v[i].sum, v[i].co, v[i].ov, exp_lat[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] es;
    logic        ec, eo;
    bit          seen;
    bit          extra;
    model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, es, ec, eo);
    ready_i = 1'b0;
    add1_i  = 32'h1234_5678;
    add2_i  = 32'h0FED_CBA9;
    sub_i   = 1'b1;
    carry_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    add1_i  = 32'hDEAD_BEEF;
    add2_i  = 32'h0BAD_F00D;
    sub_i   = 1'b0;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    seen = 1'b0;
    for (int l = 0; l < 10 && !seen; l++) begin
      if (vo_w[0] === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_valid_timeout valid=%b required 1", vo_w[0]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (vo_w[0] !== 1'b1 || sum_w[0] !== es ||
          co_w[0] !== ec || ov_w[0] !== eo) begin
        failures++;
        $display("FAIL bp_hold_%0d vo=%b sum=%h co=%b ov=%b required 1 %h %b %b",
                 k, vo_w[0], sum_w[0], co_w[0], ov_w[0], es, ec, eo);
      end
    end
    ready_i = 1'b1;
    step();
    checks++;
    if (vo_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release vo=%b rdy=%b required 0 1", vo_w[0], rdy_w[0]);
    end
    extra = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (vo_w[0] !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL bp_ignored_pulse extra_valid=%b required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] es;
    logic        ec, eo;
    bit          spur;
    ready_i = 1'b1;
    add1_i  = 32'hA5A5_A5A5;
    add2_i  = 32'h5A5A_5A5B;
    sub_i   = 1'b0;
    carry_i = 1'b0;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rdy_w[0] !== 1'b1 || vo_w[0] !== 1'b0 || sum_w[0] !== 32'h0 ||
        co_w[0] !== 1'b0 || ov_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_state rdy=%b vo=%b sum=%h co=%b ov=%b required 1 0 0 0 0",
               rdy_w[0], vo_w[0], sum_w[0], co_w[0], ov_w[0]);
    end
    step();
    step();
    rst_ni = 1'b1;
    spur = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (vo_w[0] !== 1'b0 || vo_w[1] !== 1'b0 || vo_w[2] !== 1'b0)
        spur = 1'b1;
    end
    checks++;
    if (spur) begin
      failures++;
      $display("FAIL abort_no_valid spurious=%b required 0", spur);
    end
    model(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, es, ec, eo);
    txn(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    checks++;
    if (sum_g[0] !== es || co_g[0] !== ec || ov_g[0] !== eo ||
        lat_g[0] != 4) begin
      failures++;
      $display("FAIL abort_recover sum=%h co=%b ov=%b lat=%0d required %h %b %b 4",
               sum_g[0], co_g[0], ov_g[0], lat_g[0], es, ec, eo);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, es;
    logic        s, c, ec, eo;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      c = 1'($urandom);
      if (i % 8 == 0) b = ~a;
      if (i % 8 == 1) a = 32'h8000_0000;
      model(a, b, s, c, es, ec, eo);
      txn(a, b, s, c);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (sum_g[j] !== es || co_g[j] !== ec ||
            ov_g[j] !== eo || lat_g[j] != exp_lat[j]) begin
          failures++;
          $display("FAIL random_%0d inst=%0d a=%h b=%h s=%b c=%b got %h %b %b lat=%0d required %h %b %b lat=%0d",
                   i, j, a, b, s, c, sum_g[j], co_g[j], ov_g[j], lat_g[j],
                   es, ec, eo, exp_lat[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
